// File: rtl/if_id_lane_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_lane_reg
// Brief    : IF->ID pipeline register for an N-lane front end. Holds per-lane
//            valid bits, per-lane payloads and one shared payload; keeps a
//            one-entry rdata holding buffer; counts stale instruction-memory
//            responses with a saturating cancel counter.
// Option   : define IFID_FLUSH_DATA_CLR_EN to clear the payload registers on
//            an exception or branch flush (default: payloads ignore flush).
// Revision : 1.0 - initial release
// ============================================================================
module if_id_lane_reg #(
  parameter int LANES      = 2,
  parameter int LANE_W     = 64,
  parameter int SHARED_W   = 32,
  parameter int RDATA_W    = 65,
  parameter int CANCEL_MAX = 3,
  localparam int CNT_W     = $clog2(CANCEL_MAX + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [LANES-1:0]          pre_valid_i,
  input  logic                      now_allowin_i,
  output logic [LANES-1:0]          now_valid_o,
  input  logic                      excep_flush_i,
  input  logic                      branch_flush_i,
  input  logic [LANES*LANE_W-1:0]   pre_lane_data_i,
  input  logic [SHARED_W-1:0]       pre_shared_data_i,
  output logic [LANES*LANE_W-1:0]   now_lane_data_o,
  output logic [SHARED_W-1:0]       now_shared_data_o,
  input  logic                      rdata_buf_we_i,
  input  logic [RDATA_W-1:0]        rdata_buf_i,
  output logic [RDATA_W-1:0]        rdata_buf_o,
  input  logic                      cancel_add_i,
  input  logic                      cancel_use_i,
  output logic [CNT_W-1:0]          cancel_cnt_o,
  output logic                      cancel_active_o,
  output logic                      cancel_err_o
);

  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(CANCEL_MAX);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  logic [LANES-1:0]        r_valid;
  logic [LANES*LANE_W-1:0] r_lane_data;
  logic [SHARED_W-1:0]     r_shared_data;
  logic [RDATA_W-1:0]      r_rdata_buf;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_err;

  logic                    w_ld;
  logic                    w_flush;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic                    w_err_set;

  // A payload is only worth capturing when at least one lane carries an
  // instruction and decode is ready to take it.
  assign w_ld    = (|pre_valid_i) && now_allowin_i;
  assign w_flush = excep_flush_i || branch_flush_i;

  // Valid bits: flush beats load; on allowin all lanes load together,
  // including lanes arriving invalid, so no stale lane survives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (w_flush) begin
      r_valid <= '0;
    end else if (now_allowin_i) begin
      r_valid <= pre_valid_i;
    end
  end

  // Payload registers: load/hold, optionally cleared by flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lane_data   <= '0;
      r_shared_data <= '0;
`ifdef IFID_FLUSH_DATA_CLR_EN
    end else if (w_flush) begin
      r_lane_data   <= '0;
      r_shared_data <= '0;
`endif
    end else if (w_ld) begin
      r_lane_data   <= pre_lane_data_i;
      r_shared_data <= pre_shared_data_i;
    end
  end

  // rdata holding buffer: independent of flush and allowin.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata_buf <= '0;
    end else if (rdata_buf_we_i) begin
      r_rdata_buf <= rdata_buf_i;
    end
  end

  // Cancel counter next state: saturate at CANCEL_MAX, floor at zero, and
  // flag either boundary violation; a simultaneous add/use cancels out.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_err_set = 1'b0;
    case ({cancel_add_i, cancel_use_i})
      2'b10: begin
        if (r_cnt < c_cnt_max) begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end else begin
          w_err_set = 1'b1;
        end
      end
      2'b01: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - c_cnt_one;
        end else begin
          w_err_set = 1'b1;
        end
      end
      default: begin
        w_cnt_nxt = r_cnt;
      end
    endcase
  end

  // Cancel counter and sticky error register; flushes do not touch these.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_err <= r_err || w_err_set;
    end
  end

  assign now_valid_o       = r_valid;
  assign now_lane_data_o   = r_lane_data;
  assign now_shared_data_o = r_shared_data;
  assign rdata_buf_o       = r_rdata_buf;
  assign cancel_cnt_o      = r_cnt;
  assign cancel_active_o   = (r_cnt != '0);
  assign cancel_err_o      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_if_id_lane_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_lane_reg
// Brief    : Testbench for if_id_lane_reg (LANES=2, CANCEL_MAX=3): directed
//            vector table followed by random traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_lane_reg;

  localparam int CANCEL_MAX = 3;
`ifdef IFID_FLUSH_DATA_CLR_EN
  localparam bit FCLR = 1'b1;
`else
  localparam bit FCLR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   pre_valid;
  logic         allowin, excep_flush, branch_flush;
  logic [127:0] pre_lane;
  logic [31:0]  pre_shared;
  logic         rd_we;
  logic [64:0]  rd_in;
  logic         c_add, c_use;

  logic [1:0]   now_valid;
  logic [127:0] now_lane;
  logic [31:0]  now_shared;
  logic [64:0]  rd_out;
  logic [1:0]   cnt;
  logic         active, err;

  always #5 clk = ~clk;

  if_id_lane_reg #(
    .LANES(2), .LANE_W(64), .SHARED_W(32), .RDATA_W(65), .CANCEL_MAX(CANCEL_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pre_valid_i(pre_valid), .now_allowin_i(allowin), .now_valid_o(now_valid),
    .excep_flush_i(excep_flush), .branch_flush_i(branch_flush),
    .pre_lane_data_i(pre_lane), .pre_shared_data_i(pre_shared),
    .now_lane_data_o(now_lane), .now_shared_data_o(now_shared),
    .rdata_buf_we_i(rd_we), .rdata_buf_i(rd_in), .rdata_buf_o(rd_out),
    .cancel_add_i(c_add), .cancel_use_i(c_use),
    .cancel_cnt_o(cnt), .cancel_active_o(active), .cancel_err_o(err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, written from the behavioural rules with integers.
  logic [1:0]   m_valid;
  logic [127:0] m_lane;
  logic [31:0]  m_shared;
  logic [64:0]  m_rdata;
  int           m_cnt;
  bit           m_err;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // Advance one clock, moving the model along with the DUT.
  task automatic tick();
    logic [1:0]   v;
    logic [127:0] l;
    logic [31:0]  s;
    logic [64:0]  r;
    int           c;
    bit           e;
    bit           fl;
    v = m_valid; l = m_lane; s = m_shared; r = m_rdata; c = m_cnt; e = m_err;
    fl = excep_flush || branch_flush;
    if (!rst_n) begin
      v = '0; l = '0; s = '0; r = '0; c = 0; e = 1'b0;
    end else begin
      if (fl) v = '0;
      else if (allowin) v = pre_valid;
      if (FCLR && fl) begin
        l = '0; s = '0;
      end else if (pre_valid != 2'b00 && allowin) begin
        l = pre_lane; s = pre_shared;
      end
      if (rd_we) r = rd_in;
      if (c_add && !c_use) begin
        if (c < CANCEL_MAX) c = c + 1; else e = 1'b1;
      end else if (c_use && !c_add) begin
        if (c > 0) c = c - 1; else e = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    m_valid = v; m_lane = l; m_shared = s; m_rdata = r; m_cnt = c; m_err = e;
  endtask

  typedef struct {
    logic         rst_n;
    logic [1:0]   pv;
    logic         allow, bf, ef;
    logic [127:0] lane;
    logic [31:0]  shared;
    logic         we;
    logic [64:0]  rdata;
    logic         add, cu;
    logic [1:0]   e_valid;
    logic         ck_data;
    logic [127:0] e_lane;
    logic [31:0]  e_shared;
    logic         ck_rdata;
    logic [64:0]  e_rdata;
    logic         ck_cnt;
    logic [1:0]   e_cnt;
    logic         e_err;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [1:0] pv, input logic al,
                              input logic bf, input logic ef, input logic [127:0] ln,
                              input logic [31:0] sh, input logic we, input logic [64:0] rd,
                              input logic ad, input logic cu);
    vec_t t;
    t.rst_n = r; t.pv = pv; t.allow = al; t.bf = bf; t.ef = ef; t.lane = ln;
    t.shared = sh; t.we = we; t.rdata = rd; t.add = ad; t.cu = cu;
    t.e_valid = '0; t.ck_data = 1'b0; t.e_lane = '0; t.e_shared = '0;
    t.ck_rdata = 1'b0; t.e_rdata = '0; t.ck_cnt = 1'b0; t.e_cnt = '0; t.e_err = 1'b0;
    return t;
  endfunction

  localparam int NV = 23;
  vec_t tbl[NV];

  initial begin
    logic [64:0]  rdv;
    logic [127:0] d21;
    logic [127:0] d43;
    rdv = 65'h1_DEAD_BEEF_0000_0001;
    d21 = {64'h2, 64'h1};
    d43 = {64'h4, 64'h3};

    // Full reset clears everything.
    tbl[0] = mk(0, 2'b11, 1, 0, 0, '1, '1, 1, '1, 1, 0);
    tbl[0].ck_data = 1; tbl[0].ck_rdata = 1; tbl[0].ck_cnt = 1;
    // First load, one-cycle latency.
    tbl[1] = mk(1, 2'b11, 1, 0, 0, {64'hB, 64'hA}, 32'h1C00_0000, 0, '0, 0, 0);
    tbl[1].e_valid = 2'b11; tbl[1].ck_data = 1;
    tbl[1].e_lane = {64'hB, 64'hA}; tbl[1].e_shared = 32'h1C00_0000;
    // Three cycles of stall with new inputs: everything holds.
    for (int i = 2; i <= 4; i++) begin
      tbl[i] = mk(1, 2'b10, 0, 0, 0, {64'hD, 64'hC}, 32'h5, 0, '0, 0, 0);
      tbl[i].e_valid = 2'b11; tbl[i].ck_data = 1;
      tbl[i].e_lane = {64'hB, 64'hA}; tbl[i].e_shared = 32'h1C00_0000;
    end
    // Partial-lane load.
    tbl[5] = mk(1, 2'b01, 1, 0, 0, {64'hF, 64'hE}, 32'h7, 0, '0, 0, 0);
    tbl[5].e_valid = 2'b01; tbl[5].ck_data = 1;
    tbl[5].e_lane = {64'hF, 64'hE}; tbl[5].e_shared = 32'h7;
    // Branch flush concurrent with a load.
    tbl[6] = mk(1, 2'b11, 1, 1, 0, d21, 32'h9, 0, '0, 0, 0);
    tbl[6].ck_data = 1; tbl[6].e_lane = FCLR ? '0 : d21; tbl[6].e_shared = FCLR ? '0 : 32'h9;
    // Allowin with no valid lanes: valids clear, data holds; rdata written.
    tbl[7] = mk(1, 2'b00, 1, 0, 0, d43, 32'hA, 1, rdv, 0, 0);
    tbl[7].ck_data = 1; tbl[7].e_lane = FCLR ? '0 : d21; tbl[7].e_shared = FCLR ? '0 : 32'h9;
    tbl[7].ck_rdata = 1; tbl[7].e_rdata = rdv;
    // Exception flush with we=0: rdata retained.
    tbl[8] = mk(1, 2'b11, 1, 0, 1, d43, 32'hA, 0, 65'h0_1234_5678_9ABC_DEF0, 0, 0);
    tbl[8].ck_data = 1; tbl[8].e_lane = FCLR ? '0 : d43; tbl[8].e_shared = FCLR ? '0 : 32'hA;
    tbl[8].ck_rdata = 1; tbl[8].e_rdata = rdv;
    // Four adds: 1,2,3,3 with error on saturation.
    for (int i = 9; i <= 12; i++) begin
      tbl[i] = mk(1, 2'b00, 0, 0, 0, '0, '0, 0, '0, 1, 0);
      tbl[i].ck_cnt = 1; tbl[i].e_cnt = (i == 9) ? 2'd1 : (i == 10) ? 2'd2 : 2'd3;
      tbl[i].e_err = (i == 12);
    end
    // Three uses back down to zero; error stays sticky.
    for (int i = 13; i <= 15; i++) begin
      tbl[i] = mk(1, 2'b00, 0, 0, 0, '0, '0, 0, '0, 0, 1);
      tbl[i].ck_cnt = 1; tbl[i].e_cnt = 2'(15 - i); tbl[i].e_err = 1'b1;
    end
    // Reset clears error and all state.
    tbl[16] = mk(0, 2'b00, 0, 0, 0, '0, '0, 0, '0, 0, 0);
    tbl[16].ck_data = 1; tbl[16].ck_rdata = 1; tbl[16].ck_cnt = 1;
    // add&use at zero: hold, no error.
    tbl[17] = mk(1, 2'b00, 0, 0, 0, '0, '0, 0, '0, 1, 1);
    tbl[17].ck_cnt = 1;
    // use at zero: underflow error.
    tbl[18] = mk(1, 2'b00, 0, 0, 0, '0, '0, 0, '0, 0, 1);
    tbl[18].ck_cnt = 1; tbl[18].e_err = 1'b1;
    tbl[19] = mk(0, 2'b00, 0, 0, 0, '0, '0, 0, '0, 0, 0);
    tbl[19].ck_cnt = 1;
    // Count to 2, then reset mid-count (with add asserted) clears it.
    tbl[20] = mk(1, 2'b00, 0, 0, 0, '0, '0, 0, '0, 1, 0);
    tbl[20].ck_cnt = 1; tbl[20].e_cnt = 2'd1;
    tbl[21] = mk(1, 2'b00, 0, 0, 0, '0, '0, 0, '0, 1, 0);
    tbl[21].ck_cnt = 1; tbl[21].e_cnt = 2'd2;
    tbl[22] = mk(0, 2'b00, 0, 0, 0, '0, '0, 0, '0, 1, 0);
    tbl[22].ck_cnt = 1;

    // Power-up: hold reset for two edges.
    rst_n = 0; pre_valid = '0; allowin = 0; excep_flush = 0; branch_flush = 0;
    pre_lane = '0; pre_shared = '0; rd_we = 0; rd_in = '0; c_add = 0; c_use = 0;
    m_valid = '0; m_lane = '0; m_shared = '0; m_rdata = '0; m_cnt = 0; m_err = 0;
    repeat (2) tick();

    // Directed vectors.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst_n = tbl[i].rst_n; pre_valid = tbl[i].pv; allowin = tbl[i].allow;
      branch_flush = tbl[i].bf; excep_flush = tbl[i].ef; pre_lane = tbl[i].lane;
      pre_shared = tbl[i].shared; rd_we = tbl[i].we; rd_in = tbl[i].rdata;
      c_add = tbl[i].add; c_use = tbl[i].cu;
      tick();
      chk($sformatf("v%0d valid", i), 128'(now_valid), 128'(tbl[i].e_valid));
      if (tbl[i].ck_data) begin
        chk($sformatf("v%0d lane", i), now_lane, tbl[i].e_lane);
        chk($sformatf("v%0d shared", i), 128'(now_shared), 128'(tbl[i].e_shared));
      end
      if (tbl[i].ck_rdata)
        chk($sformatf("v%0d rdata", i), 128'(rd_out), 128'(tbl[i].e_rdata));
      if (tbl[i].ck_cnt) begin
        chk($sformatf("v%0d cnt", i), 128'(cnt), 128'(tbl[i].e_cnt));
        chk($sformatf("v%0d err", i), 128'(err), 128'(tbl[i].e_err));
        chk($sformatf("v%0d active", i), 128'(active), 128'(tbl[i].e_cnt != 2'd0));
      end
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rst_n        = ($urandom_range(0, 39) != 0);
      pre_valid    = 2'($urandom);
      allowin      = ($urandom_range(0, 3) != 0);
      excep_flush  = ($urandom_range(0, 9) == 0);
      branch_flush = ($urandom_range(0, 7) == 0);
      pre_lane     = {$urandom, $urandom, $urandom, $urandom};
      pre_shared   = $urandom;
      rd_we        = ($urandom_range(0, 2) == 0);
      rd_in        = {1'($urandom), $urandom, $urandom};
      c_add        = 1'($urandom);
      c_use        = 1'($urandom);
      tick();
      chk("r valid", 128'(now_valid), 128'(m_valid));
      chk("r lane", now_lane, m_lane);
      chk("r shared", 128'(now_shared), 128'(m_shared));
      chk("r rdata", 128'(rd_out), 128'(m_rdata));
      chk("r cnt", 128'(cnt), 128'(m_cnt));
      chk("r active", 128'(active), 128'(m_cnt != 0));
      chk("r err", 128'(err), 128'(m_err));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_id_lane_reg.md
Name: if_id_lane_reg

Overview:
Parametrised IF→ID pipeline register for an N-lane front end.
- Holds per-lane valid bits and per-lane payloads, plus one shared payload; honours exception and branch flush.
- Keeps a one-entry instruction-rdata holding buffer.
- Tracks stale instruction-memory responses with a saturating cancel counter of configurable depth, generalising the fixed two-level discard FSM.
- Sits between fetch and decode in the dual-issue pipeline.

Parameters:
LANES, 2, number of issue lanes (1..4)
LANE_W, 64, payload width per lane
SHARED_W, 32, width of payload common to all lanes
RDATA_W, 65, width of rdata holding buffer
CANCEL_MAX, 3, maximum outstanding responses to discard (≥1)
CNT_W, $clog2(CANCEL_MAX+1), cancel counter width (derived, not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active low
pre_valid_i  in  LANES  per-lane valid from fetch
now_allowin_i  in  1  decode can accept
now_valid_o  out  LANES  registered per-lane valid
excep_flush_i  in  1  exception flush
branch_flush_i  in  1  branch-mispredict flush
pre_lane_data_i  in  LANES*LANE_W  lane payloads, lane 0 in LSBs
pre_shared_data_i  in  SHARED_W  shared payload
now_lane_data_o  out  LANES*LANE_W  registered lane payloads
now_shared_data_o  out  SHARED_W  registered shared payload
rdata_buf_we_i  in  1  rdata buffer write enable
rdata_buf_i  in  RDATA_W  rdata buffer write data
rdata_buf_o  out  RDATA_W  rdata buffer contents
cancel_add_i  in  1  one more in-flight response becomes stale
cancel_use_i  in  1  one stale response has arrived and been dropped
cancel_cnt_o  out  CNT_W  current stale-response count
cancel_active_o  out  1  cancel_cnt_o != 0 (combinational from register)
cancel_err_o  out  1  sticky error: saturation or underflow attempted

Behaviour:
- Reset: clock is clk; reset is synchronous, active-low on rst_n. All outputs reset to 0: now_valid_o, both data outputs, rdata_buf_o, cancel_cnt_o, cancel_err_o.
- Load condition `ld` = (|pre_valid_i) && now_allowin_i.
- Data path:
  - On `ld`, both data registers capture their inputs at the next edge; otherwise they hold.
  - Latency is 1 cycle.
  - Flush does not alter the data registers (see Optional Feature).
- Valid, priority order:
  1. !rst_n or excep_flush_i or branch_flush_i → now_valid_o = 0.
  2. Else if now_allowin_i → now_valid_o = pre_valid_i. All lanes load together, including lanes whose valid is 0.
  3. Else hold.
  - Flush wins over a simultaneous load.
- rdata buffer: on rdata_buf_we_i it loads rdata_buf_i; otherwise holds. It is independent of flush and allowin.
- Cancel counter `cnt`, single register, next value:
  - add && !use: if cnt < CANCEL_MAX then cnt+1; else hold and set cancel_err_o.
  - use && !add: if cnt > 0 then cnt−1; else hold at 0 and set cancel_err_o.
  - add && use: hold. This holds even when cnt=0 and when cnt=CANCEL_MAX; cancel_err_o is not set.
  - neither: hold.
- cancel_err_o is sticky until reset.
- Flushes do not affect the counter.
- With CANCEL_MAX=2 the counter is cycle-equivalent to the old Reset/Clear1/Clear2 FSM for inputs 10/01/00.

Optional Feature:
IFID_FLUSH_DATA_CLR_EN
- Defined: when excep_flush_i or branch_flush_i is asserted, now_lane_data_o and now_shared_data_o clear to 0 at the next edge. This overrides `ld`.
- Undefined: data registers ignore flush and follow the load/hold rule only.

Test Plan:
- Reset, then LANES=2, pre_valid_i=2'b11, allowin=1, lane data {64'hB,64'hA}, shared 32'h1C000000 → next cycle now_valid_o=2'b11, now_lane_data_o={B,A}, now_shared_data_o=1C000000.
- Hold: allowin=0 for 3 cycles with new inputs → outputs unchanged. Then pre_valid_i=2'b01 with allowin=1 → now_valid_o=2'b01.
- Flush: branch_flush_i=1 concurrent with `ld` → now_valid_o=0.
  - Data updated without IFID_FLUSH_DATA_CLR_EN.
  - Data = 0 with IFID_FLUSH_DATA_CLR_EN.
- Cancel, CANCEL_MAX=3: 4× add → cnt 1,2,3,3 and cancel_err_o=1 on the 4th. Then 3× use → cnt 0 and cancel_active_o=0.
- Cancel edge cases:
  - add&use at cnt=0 → cnt stays 0, no error.
  - use at cnt=0 → cnt=0, cancel_err_o=1.
  - rst_n=0 mid-count (cnt=2) → cnt=0, err=0 after that edge.
- rdata buffer: we=1 with 65'h1_DEAD_BEEF_0000_0001 → rdata_buf_o equals it. Then we=0 plus flush → value retained.
